// File: rtl/sram_boot_loader.sv
// rtl/sram_boot_loader.sv - copies a program ROM image into external SRAM after reset,
// holding the CPU in reset, then hands the SRAM controls to the CPU unchanged.
module sram_boot_loader #(
  parameter int          NUM_WORDS = 256,
  parameter int          ROM_AW    = 8,
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter int          WE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [ROM_AW-1:0] Rom_Addr,
  input  logic [15:0]       Rom_Data,
  input  logic              CPU_CE,
  input  logic              CPU_UB,
  input  logic              CPU_LB,
  input  logic              CPU_OE,
  input  logic              CPU_WE,
  input  logic [19:0]       CPU_ADDR,
  input  logic [15:0]       CPU_Data_to_SRAM,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [19:0]       ADDR,
  output logic [15:0]       Data_to_SRAM,
  output logic              Drive_En,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Done
);

  localparam int               IDX_W    = ROM_AW + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [3:0]       WE_LAST  = 4'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [3:0]       we_cnt;
  logic [15:0]      data_reg;
  logic [19:0]      copy_addr;
  logic [ROM_AW-1:0] rom_next;

  assign copy_addr = BASE_ADDR + 20'(idx);
  assign rom_next  = idx[ROM_AW-1:0] + {{(ROM_AW-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx      <= '0;
      we_cnt   <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        ST_FETCH: data_reg <= Rom_Data;
        ST_SETUP: we_cnt <= '0;
        ST_WRITE: if (we_cnt != WE_LAST) we_cnt <= we_cnt + 4'd1;
        ST_HOLD:  if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        ST_DONE:  if (Start) idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: state_next = ST_SETUP;
      ST_SETUP: state_next = ST_WRITE;
      ST_WRITE: if (we_cnt == WE_LAST) state_next = ST_HOLD;
      ST_HOLD:  state_next = (idx == LAST_IDX) ? ST_DONE : ST_FETCH;
      ST_DONE:  if (Start) state_next = ST_FETCH;
      default:  state_next = ST_FETCH;
    endcase
  end

  // The ROM has one cycle of latency, so HOLD already presents the next word's
  // address and DONE presents word 0, leaving the data valid during FETCH.
  always_comb begin
    CE           = 1'b1;
    UB           = 1'b1;
    LB           = 1'b1;
    OE           = 1'b1;
    WE           = 1'b1;
    ADDR         = '0;
    Data_to_SRAM = '0;
    Drive_En     = 1'b0;
    Busy         = 1'b1;
    Done         = 1'b0;
    Cpu_Hold     = 1'b1;
    Rom_Addr     = idx[ROM_AW-1:0];
    case (state)
      ST_SETUP, ST_WRITE, ST_HOLD: begin
        CE           = 1'b0;
        UB           = 1'b0;
        LB           = 1'b0;
        WE           = (state == ST_WRITE) ? 1'b0 : 1'b1;
        ADDR         = copy_addr;
        Data_to_SRAM = data_reg;
        Drive_En     = 1'b1;
        if (state == ST_HOLD) Rom_Addr = rom_next;
      end
      ST_DONE: begin
        CE           = CPU_CE;
        UB           = CPU_UB;
        LB           = CPU_LB;
        OE           = CPU_OE;
        WE           = CPU_WE;
        ADDR         = CPU_ADDR;
        Data_to_SRAM = CPU_Data_to_SRAM;
        Drive_En     = ~CPU_WE;
        Busy         = 1'b0;
        Done         = 1'b1;
        Cpu_Hold     = 1'b0;
        Rom_Addr     = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_boot_loader.sv
// tb/tb_sram_boot_loader.sv - self-checking bench for sram_boot_loader with ROM and SRAM models.
module tb_sram_boot_loader;

  localparam int NW  = 4;
  localparam int WEC = 2;
  localparam int PER_COPY = NW * (WEC + 3);

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        CPU_CE = 1'b1, CPU_UB = 1'b1, CPU_LB = 1'b1, CPU_OE = 1'b1, CPU_WE = 1'b1;
  logic [19:0] CPU_ADDR = '0;
  logic [15:0] CPU_Data_to_SRAM = '0;

  logic [1:0]  Rom_Addr, w_Rom_Addr;
  logic [15:0] rom_q, w_rom_q;
  logic        CE, UB, LB, OE, WE, Drive_En, Cpu_Hold, Busy, Done;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        w_CE, w_UB, w_LB, w_OE, w_WE, w_Drive_En, w_Cpu_Hold, w_Busy, w_Done;
  logic [19:0] w_ADDR;
  logic [15:0] w_Data_to_SRAM;

  logic [15:0] rom [NW];
  logic [15:0] mem [int];
  logic [15:0] w_mem [int];

  int total = 0;
  int bad = 0;
  int mon_bad = 0;
  int mon_pulses = 0;
  int run_len = 0;
  logic p_busy = 1'b0, p_we = 1'b1, p_ce = 1'b1, p_de = 1'b0;
  logic [19:0] p_addr = '0;
  logic [15:0] p_data = '0;

  always #5 Clk = ~Clk;

  sram_boot_loader #(.NUM_WORDS(NW), .ROM_AW(2), .BASE_ADDR(20'h00010), .WE_CYCLES(WEC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rom_Addr(Rom_Addr), .Rom_Data(rom_q),
    .CPU_CE(CPU_CE), .CPU_UB(CPU_UB), .CPU_LB(CPU_LB), .CPU_OE(CPU_OE), .CPU_WE(CPU_WE),
    .CPU_ADDR(CPU_ADDR), .CPU_Data_to_SRAM(CPU_Data_to_SRAM),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
    .Drive_En(Drive_En), .Cpu_Hold(Cpu_Hold), .Busy(Busy), .Done(Done));

  sram_boot_loader #(.NUM_WORDS(NW), .ROM_AW(2), .BASE_ADDR(20'hFFFFE), .WE_CYCLES(WEC)) dut_w (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rom_Addr(w_Rom_Addr), .Rom_Data(w_rom_q),
    .CPU_CE(CPU_CE), .CPU_UB(CPU_UB), .CPU_LB(CPU_LB), .CPU_OE(CPU_OE), .CPU_WE(CPU_WE),
    .CPU_ADDR(CPU_ADDR), .CPU_Data_to_SRAM(CPU_Data_to_SRAM),
    .CE(w_CE), .UB(w_UB), .LB(w_LB), .OE(w_OE), .WE(w_WE), .ADDR(w_ADDR),
    .Data_to_SRAM(w_Data_to_SRAM), .Drive_En(w_Drive_En), .Cpu_Hold(w_Cpu_Hold),
    .Busy(w_Busy), .Done(w_Done));

  // Synchronous ROM with one cycle of read latency.
  always @(posedge Clk) begin
    rom_q   <= rom[Rom_Addr];
    w_rom_q <= rom[w_Rom_Addr];
  end

  // SRAM: a word is stored whenever the chip is selected with WE low.
  always @(negedge Clk) begin
    if (CE === 1'b0 && WE === 1'b0) mem[int'(ADDR)] = Data_to_SRAM;
    if (w_CE === 1'b0 && w_WE === 1'b0) w_mem[int'(w_ADDR)] = w_Data_to_SRAM;
  end

  // Write-strobe timing observer for the copy phase.
  always @(negedge Clk) begin
    if (Reset) begin
      p_busy = 1'b0;
      run_len = 0;
      p_we = 1'b1;
    end else begin
      if (p_busy && Busy) begin
        if (WE === 1'b0) begin
          if (CE !== 1'b0 || OE !== 1'b1 || Drive_En !== 1'b1) mon_bad++;
          run_len++;
        end
        if (p_we === 1'b1 && WE === 1'b0 &&
            (ADDR !== p_addr || Data_to_SRAM !== p_data || p_ce !== 1'b0 || p_de !== 1'b1))
          mon_bad++;
        if (p_we === 1'b0 && WE === 1'b1) begin
          if (ADDR !== p_addr || Data_to_SRAM !== p_data || CE !== 1'b0 || Drive_En !== 1'b1)
            mon_bad++;
          if (run_len != WEC) mon_bad++;
          mon_pulses++;
          run_len = 0;
        end
      end
      p_busy = Busy;
      p_we   = WE;
      p_ce   = CE;
      p_de   = Drive_En;
      p_addr = ADDR;
      p_data = Data_to_SRAM;
    end
  end

  task automatic load_random_rom();
    for (int i = 0; i < NW; i++) rom[i] = 16'($urandom);
  endtask

  task automatic hold_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    mem.delete();
    w_mem.delete();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic run_until_done(input int start_at, output int cycles);
    cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge Clk);
      #1;
      cycles++;
      if (Done === 1'b1) break;
      Start = (cycles == start_at);
    end
    Start = 1'b0;
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < NW; i++) begin
      int a = 16 + i;
      int wa = (20'hFFFFE + i) & 20'hFFFFF;
      logic [15:0] got = mem.exists(a) ? mem[a] : 16'hxxxx;
      logic [15:0] wgot = w_mem.exists(wa) ? w_mem[wa] : 16'hxxxx;
      total++;
      if (got !== rom[i]) begin
        bad++;
        $display("FAIL %s word%0d addr=%05h got=%04h exp=%04h", name, i, a, got, rom[i]);
      end
      total++;
      if (wgot !== rom[i]) begin
        bad++;
        $display("FAIL %s wrap word%0d addr=%05h got=%04h exp=%04h", name, i, wa, wgot, rom[i]);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({CE, UB, LB, OE, WE, Drive_En} !== 6'b111110) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=111110", {CE, UB, LB, OE, WE, Drive_En});
    end
    total++;
    if (ADDR !== 20'h0 || Data_to_SRAM !== 16'h0 || Rom_Addr !== 2'd0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h rom_addr=%h exp=0", ADDR, Data_to_SRAM, Rom_Addr);
    end
    total++;
    if ({Busy, Done, Cpu_Hold} !== 3'b101) begin
      bad++;
      $display("FAIL reset_status got=%b exp=101", {Busy, Done, Cpu_Hold});
    end
  endtask

  task automatic test_copy();
    int cyc;
    rom[0] = 16'h1234; rom[1] = 16'hABCD; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
    hold_reset();
    run_until_done(0, cyc);
    total++;
    if (cyc != PER_COPY) begin
      bad++;
      $display("FAIL copy_latency got=%0d exp=%0d", cyc, PER_COPY);
    end
    total++;
    if ({Cpu_Hold, Busy, w_Done} !== 3'b001) begin
      bad++;
      $display("FAIL copy_status hold_busy_wdone got=%b exp=001", {Cpu_Hold, Busy, w_Done});
    end
    check_image("copy");
  endtask

  task automatic test_setup_hold();
    int cyc;
    load_random_rom();
    hold_reset();
    mon_bad = 0;
    mon_pulses = 0;
    run_until_done(0, cyc);
    total++;
    if (mon_bad != 0) begin
      bad++;
      $display("FAIL setup_hold violations got=%0d exp=0", mon_bad);
    end
    total++;
    if (mon_pulses != NW) begin
      bad++;
      $display("FAIL setup_hold pulses got=%0d exp=%0d", mon_pulses, NW);
    end
    check_image("setup_hold");
  endtask

  task automatic test_pass_through();
    @(negedge Clk);
    CPU_ADDR = 20'h00ABC; CPU_WE = 1'b0; CPU_Data_to_SRAM = 16'h5A5A; CPU_CE = 1'b0;
    #1;
    total++;
    if (ADDR !== 20'h00ABC || Data_to_SRAM !== 16'h5A5A || Drive_En !== 1'b1 || WE !== 1'b0) begin
      bad++;
      $display("FAIL pass_write addr=%h data=%h de=%b we=%b exp=00abc 5a5a 1 0",
               ADDR, Data_to_SRAM, Drive_En, WE);
    end
    CPU_WE = 1'b1; CPU_OE = 1'b0;
    #1;
    total++;
    if (Drive_En !== 1'b0 || OE !== 1'b0) begin
      bad++;
      $display("FAIL pass_read de=%b oe=%b exp=0 0", Drive_En, OE);
    end
    for (int i = 0; i < 8; i++) begin
      logic [4:0] c = 5'($urandom);
      CPU_CE = c[4]; CPU_UB = c[3]; CPU_LB = c[2]; CPU_OE = c[1]; CPU_WE = c[0];
      CPU_ADDR = 20'($urandom);
      CPU_Data_to_SRAM = 16'($urandom);
      #2;
      total++;
      if ({CE, UB, LB, OE, WE} !== c || ADDR !== CPU_ADDR || Data_to_SRAM !== CPU_Data_to_SRAM ||
          Drive_En !== ~c[0]) begin
        bad++;
        $display("FAIL pass_rand%0d ctl=%b addr=%h data=%h de=%b exp ctl=%b addr=%h data=%h de=%b",
                 i, {CE, UB, LB, OE, WE}, ADDR, Data_to_SRAM, Drive_En, c, CPU_ADDR,
                 CPU_Data_to_SRAM, ~c[0]);
      end
    end
    CPU_CE = 1'b1; CPU_UB = 1'b1; CPU_LB = 1'b1; CPU_OE = 1'b1; CPU_WE = 1'b1;
  endtask

  task automatic test_reset_mid_copy();
    int cyc;
    bit found = 1'b0;
    load_random_rom();
    hold_reset();
    for (int k = 0; k < 60; k++) begin
      @(posedge Clk);
      #1;
      if (WE === 1'b0 && ADDR === 20'h00012) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL abort_reach_word2 got=0 exp=1");
    end
    #2;
    Reset = 1'b1;
    #1;
    total++;
    if (WE !== 1'b1 || Drive_En !== 1'b0 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_immediate we=%b de=%b busy=%b exp=1 0 1", WE, Drive_En, Busy);
    end
    for (int i = 0; i < NW; i++) rom[i] = rom[i] ^ 16'h8421;
    hold_reset();
    run_until_done(0, cyc);
    total++;
    if (cyc != PER_COPY) begin
      bad++;
      $display("FAIL abort_restart_latency got=%0d exp=%0d", cyc, PER_COPY);
    end
    check_image("abort");
  endtask

  task automatic test_start();
    int cyc;
    load_random_rom();
    hold_reset();
    run_until_done(7, cyc);
    total++;
    if (cyc != PER_COPY) begin
      bad++;
      $display("FAIL start_ignored latency got=%0d exp=%0d", cyc, PER_COPY);
    end
    load_random_rom();
    mem.delete();
    w_mem.delete();
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    total++;
    if ({Busy, Cpu_Hold, Done} !== 3'b110) begin
      bad++;
      $display("FAIL start_restart busy_hold_done got=%b exp=110", {Busy, Cpu_Hold, Done});
    end
    run_until_done(0, cyc);
    total++;
    if (cyc != PER_COPY) begin
      bad++;
      $display("FAIL start_latency got=%0d exp=%0d", cyc, PER_COPY);
    end
    check_image("start");
  endtask

  task automatic test_random_copies();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      load_random_rom();
      hold_reset();
      run_until_done(0, cyc);
      total++;
      if (cyc != PER_COPY || w_Done !== 1'b1) begin
        bad++;
        $display("FAIL rand_copy%0d latency=%0d wdone=%b exp=%0d 1", r, cyc, w_Done, PER_COPY);
      end
      check_image("rand_copy");
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) rom[i] = '0;
    test_reset();
    test_copy();
    test_setup_hold();
    test_pass_through();
    test_reset_mid_copy();
    test_start();
    test_random_copies();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
